instr_mem_arb_port: RTL and testbench
=====================================

INSTR_MEM_ARB_PORT -- requirements
Module: instr_mem_arb_port

Interface
REQ-001 Parameter ADDR_W, default 32, fetch address width in bits.
REQ-002 Parameter DATA_W, default 32, instruction word width in bits.
REQ-003 Parameter MEM_LAT, default 2, memory read latency in cycles, legal range 1..4.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-006 req_valid  input  8  per-requestor fetch request.
REQ-007 req_addr  input  8*ADDR_W  per-requestor fetch address; slice i is bits [i*ADDR_W +: ADDR_W].
REQ-008 req_ready  output  8  per-requestor accept; at most one bit high per cycle.
REQ-009 rsp_valid  output  8  per-requestor response strobe; at most one bit high per cycle.
REQ-010 rsp_data  output  DATA_W  response word, shared by all requestors, qualified by rsp_valid.
REQ-011 mem_rd_en  output  1  memory read strobe.
REQ-012 mem_addr  output  ADDR_W  memory read address.
REQ-013 mem_rdata  input  DATA_W  memory read data, valid exactly MEM_LAT cycles after mem_rd_en.

Function
REQ-014 Handshake i occurs in a cycle where req_valid[i] and req_ready[i] are both 1; a requestor holds req_valid and req_addr stable until its handshake.
REQ-015 Eligible vector: elig[i] = req_valid[i] and not pending[i]; pending[i] is set by handshake i and cleared at the end of the cycle rsp_valid[i]=1.
REQ-016 req_ready = round-robin grant over elig; the priority pointer moves to (granted index + 1) mod 8 after each grant and holds when there is no grant.
REQ-017 Pointer reset value is 0, i.e. index 0 has highest priority first.
REQ-018 mem_rd_en = OR of req_ready; mem_addr = req_addr slice of the granted index, 0 when there is no grant; both are combinational in the handshake cycle.
REQ-019 A tag pipeline of MEM_LAT stages carries {valid, 3-bit index}; stage 0 loads the handshake in the same cycle as mem_rd_en.
REQ-020 For a handshake at cycle T, rsp_valid[index]=1 only in cycle T+MEM_LAT, with rsp_data = mem_rdata in that cycle, combinational.
REQ-021 rsp_data = 0 whenever rsp_valid = 0.
REQ-022 Throughput: one handshake per cycle in aggregate; per requestor at most one outstanding request, next grant no earlier than T+MEM_LAT+1.
REQ-023 Simultaneous response and new request on the same index: the request is not eligible that cycle and becomes eligible the next cycle.
REQ-024 Responses return in issue order; no request is dropped or duplicated outside reset.

Reset
REQ-025 Reset asserted: pointer=0, pending=0, all tag stages invalid; req_ready=0, rsp_valid=0, mem_rd_en=0, mem_addr=0, rsp_data=0, regardless of clock.
REQ-026 Reset mid-operation discards all in-flight requests; no rsp_valid for them after deassertion; requestors re-issue.
REQ-027 First handshake possible in the first posedge after reset deassertion.

Structure
REQ-028 A shared package holds N_REQ=8, IDX_W=3, and the tag struct {valid, idx}.
REQ-029 One sub-module, instr_req_rr_arb: 8-bit round-robin arbiter with clk/rst (async active-low), req/gnt ports and internal pointer; the tag pipeline and pending logic live in the top.

Verification (MEM_LAT=2)
REQ-030 Single request: req_valid=8'h04, addr 0x100 at cycle 1 -> req_ready=8'h04, mem_rd_en=1, mem_addr=0x100 at cycle 1; rsp_valid=8'h04, rsp_data=mem_rdata at cycle 3.
REQ-031 All 8 request continuously from reset -> grants in order 0,1,...,7, then 0 again at cycle 8 (pending released), with one mem_rd_en per cycle.
REQ-032 req_valid=8'h81 held with pointer at 1 -> grant 7, then 0, then 7 again after pending clears; no starvation.
REQ-033 Requestor 3 re-asserts in its response cycle -> no grant that cycle, grant in the next cycle, rsp_valid[3] is a single-cycle pulse.
REQ-034 rst pulsed low mid-cycle with 2 requests in flight -> outputs 0 immediately, no rsp_valid after release, pointer restarts at 0.
REQ-035 Random stimulus -> scoreboard: every handshake yields exactly one response to the same index after exactly MEM_LAT cycles, with matching data.

Source files
------------

// File: rtl/instr_mem_arb_port_pkg.sv
// Shared constants and tag type for the instruction-memory arbitration port.
package instr_mem_arb_port_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/instr_req_rr_arb.sv
// 8-way round-robin arbiter; the pointer marks the highest-priority index.
module instr_req_rr_arb
    import instr_mem_arb_port_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr;

    // Search starts at ptr and wraps naturally through the 3-bit sum.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!gnt_any && req[ptr + IDX_W'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = ptr + IDX_W'(k);
            end
        end
        if (!rst) begin
            gnt_any = 1'b0;
            gnt_idx = '0;
        end
        gnt = gnt_any ? idx_to_onehot(gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/instr_mem_arb_port.sv
// Shares one fixed-latency instruction memory read port among 8 fetch requestors.
module instr_mem_arb_port
    import instr_mem_arb_port_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata
);

    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_any;
    tag_t             tag_pipe [MEM_LAT];
    tag_t             rsp_tag;

    assign elig = req_valid & ~pending;

    instr_req_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign req_ready = gnt;
    assign mem_rd_en = gnt_any;
    assign mem_addr  = gnt_any ? req_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;

    // pending clears at the end of the response cycle, so a same-cycle re-request waits one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_t'{valid: gnt_any, idx: gnt_idx};
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            pending <= (pending & ~rsp_valid) | gnt;
        end
    end

    assign rsp_tag   = tag_pipe[MEM_LAT-1];
    assign rsp_valid = rsp_tag.valid ? idx_to_onehot(rsp_tag.idx) : '0;
    assign rsp_data  = rsp_tag.valid ? mem_rdata : '0;

endmodule

// File: tb/tb_instr_mem_arb_port.sv
// Scoreboard bench: driver pushes expected responses, a negedge monitor pops and compares.
module tb_instr_mem_arb_port;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    req_valid;
    logic [8*AW-1:0] req_addr;
    logic [7:0]    req_ready;
    logic [7:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    instr_mem_arb_port #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    logic [31:0] ra [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model: data for an address read at cycle T appears at cycle T+2.
    logic        mv0 = 1'b0, mv1 = 1'b0;
    logic [31:0] ma0 = '0, ma1 = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mv0 <= mem_rd_en;
        ma0 <= mem_addr;
        mv1 <= mv0;
        ma1 <= ma0;
    end
    assign mem_rdata = mv1 ? mem_word(ma1) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missed_rsp: idx %0d due cycle %0d, no response by cycle %0d", e.idx, e.due, cyc);
            end
            if (rsp_valid != 8'h00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(8'(1) << e.idx));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end else begin
                check("rsp_data_idle", 64'(rsp_data), 64'h0);
            end
        end
    end

    task automatic drive_cycle(input logic [7:0] vld, input bit chk, input logic [7:0] exp_gnt,
                               output logic [7:0] hs);
        logic [7:0]  g;
        logic [31:0] ea;
        @(posedge clk);
        #1;
        req_valid = vld;
        for (int i = 0; i < 8; i++) req_addr[i*AW +: AW] = ra[i];
        @(negedge clk);
        if (chk) begin
            check("req_ready", 64'(req_ready), 64'(exp_gnt));
            g = exp_gnt;
        end else begin
            check("ready_legal", 64'((req_ready & (req_ready - 8'd1)) | (req_ready & ~vld)), 64'h0);
            g = req_ready & vld;
        end
        check("mem_rd_en", 64'(mem_rd_en), 64'(|g));
        ea = '0;
        for (int i = 0; i < 8; i++) if (g[i]) ea = ra[i];
        check("mem_addr", 64'(mem_addr), 64'(ea));
        for (int i = 0; i < 8; i++)
            if (g[i]) exp_q.push_back(exp_t'{idx: 3'(i), data: mem_word(ra[i]), due: cyc + LAT});
        hs = g;
    endtask

    task automatic step(input logic [7:0] vld, input logic [7:0] exp_gnt);
        logic [7:0] unused_hs;
        drive_cycle(vld, 1'b1, exp_gnt, unused_hs);
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h00, 8'h00);
    endtask

    // Pulse reset between clock edges with every request line high.
    task automatic do_reset();
        #1 rst = 1'b0;
        req_valid = 8'hFF;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'h0);
        check("rst_mem_addr",  64'(mem_addr),  64'h0);
        check("rst_rsp_data",  64'(rsp_data),  64'h0);
        exp_q.delete();
        req_valid = 8'h00;
        #1 rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hold;
        logic [7:0] hs;
        int unsigned wcnt [8];

        rst       = 1'b1;
        req_valid = 8'h00;
        req_addr  = '0;
        for (int i = 0; i < 8; i++) ra[i] = 32'h1000 + 32'(i) * 32'h10;
        #1 do_reset();

        // Single request
        ra[2] = 32'h100;
        step(8'h04, 8'h04);
        idle(4);

        // 0 and 7 contend with the pointer at 1
        do_reset();
        step(8'h01, 8'h01);
        step(8'h81, 8'h80);
        step(8'h81, 8'h00);
        step(8'h81, 8'h01);
        step(8'h81, 8'h80);
        step(8'h81, 8'h00);
        step(8'h81, 8'h01);
        step(8'h81, 8'h80);
        idle(4);

        // All eight request continuously
        do_reset();
        for (int c = 0; c < 16; c++) step(8'hFF, 8'(1) << (c % 8));
        idle(4);

        // Requestor 3 re-asserts in its response cycle
        do_reset();
        step(8'h08, 8'h08);
        step(8'h00, 8'h00);
        step(8'h08, 8'h00);
        step(8'h08, 8'h08);
        idle(4);

        // Reset with two requests in flight
        do_reset();
        step(8'h03, 8'h01);
        step(8'h02, 8'h02);
        do_reset();
        idle(4);
        step(8'h81, 8'h01);
        step(8'h80, 8'h80);
        idle(4);

        // Random traffic, requests held until handshake
        do_reset();
        hold = 8'h00;
        for (int i = 0; i < 8; i++) wcnt[i] = 0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (!hold[i] && c < 260 && $urandom_range(0, 2) == 0) begin
                    hold[i] = 1'b1;
                    ra[i]   = $urandom;
                    wcnt[i] = 0;
                end
            end
            drive_cycle(hold, 1'b0, 8'h00, hs);
            for (int i = 0; i < 8; i++) begin
                if (hs[i]) begin
                    hold[i] = 1'b0;
                    check("grant_wait", 64'(wcnt[i] <= 12), 64'h1);
                end else if (hold[i]) begin
                    wcnt[i]++;
                end
            end
        end
        check("all_granted", 64'(hold), 64'h0);
        idle(4);
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
